// File: rtl/wr_channel_rr_selector.sv
// Round-robin write-channel selector that holds each grant for a whole packet and
// forwards beats through one registered output stage. Define WSEL_TIMEOUT_EN for a per-grant beat limit.
module wr_channel_rr_selector #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 256,
  parameter int PORT_W    = 4,
  parameter int MAX_BEATS = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_eop,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_eop,
  output logic [PORT_W-1:0]           out_port,
  input  logic                        out_ready,
  output logic [NUM_PORTS-1:0]        enabled,
  output logic                        busy,
  output logic                        timeout_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam int SUM_W = PORT_W + 1;

  state_t               state_reg, state_next;
  logic [NUM_PORTS-1:0] enabled_reg, enabled_next;
  logic [PORT_W-1:0]    grant_reg, grant_next;
  logic [PORT_W-1:0]    ptr_reg, ptr_next;
  logic                 out_valid_reg, out_eop_reg;
  logic [DATA_W-1:0]    out_data_reg;
  logic [PORT_W-1:0]    out_port_reg;

  logic [DATA_W-1:0]    port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] pick_onehot;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_found;
  logic [SUM_W-1:0]     pick_sum;
  logic                 can_load, accept, sel_eop, force_eop, last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_data[gi]   = in_data[gi*DATA_W +: DATA_W];
      assign pick_onehot[gi] = (pick_idx == PORT_W'(gi));
      // in_ready depends only on registered state and out_ready, never on in_valid
      assign in_ready[gi]    = (state_reg == LOCKED) & enabled_reg[gi] & can_load;
    end
  endgenerate

  assign can_load  = ~out_valid_reg | out_ready;
  assign sel_eop   = in_eop[grant_reg];
  assign accept    = (state_reg == LOCKED) & in_valid[grant_reg] & can_load;
  assign last_beat = sel_eop | force_eop;

  // First requester at or after the pointer, wrapping past the last port.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    pick_sum   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pick_sum = {1'b0, ptr_reg} + SUM_W'(k);
      if (pick_sum >= SUM_W'(NUM_PORTS)) pick_sum = pick_sum - SUM_W'(NUM_PORTS);
      if (!pick_found && in_valid[pick_sum[PORT_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[PORT_W-1:0];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    enabled_next = enabled_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next   = LOCKED;
          enabled_next = pick_onehot;
          grant_next   = pick_idx;
        end
      end
      LOCKED: begin
        if (accept && last_beat) begin
          state_next   = IDLE;
          enabled_next = '0;
          ptr_next     = (grant_reg == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      enabled_reg   <= '0;
      grant_reg     <= '0;
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_eop_reg   <= 1'b0;
      out_port_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      enabled_reg <= enabled_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= port_data[grant_reg];
        out_eop_reg   <= last_beat;
        out_port_reg  <= grant_reg;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef WSEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] beat_cnt_reg;
  logic             timeout_reg;

  // The MAX_BEATS-th beat of a grant closes the packet unless it already carries eop.
  assign force_eop = (beat_cnt_reg == CNT_W'(MAX_BEATS - 1)) & ~sel_eop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= accept & force_eop;
      if (state_reg == IDLE) beat_cnt_reg <= '0;
      else if (accept)       beat_cnt_reg <= beat_cnt_reg + 1'b1;
    end
  end

  assign timeout_err = timeout_reg;
`else
  assign force_eop   = 1'b0;
  // Constant 0 in this build; the beat limit has no effect without the counter.
  assign timeout_err = (MAX_BEATS < 0);
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_eop   = out_eop_reg;
  assign out_port  = out_port_reg;
  assign enabled   = enabled_reg;
  assign busy      = (state_reg == LOCKED);

endmodule

// File: tb/tb_wr_channel_rr_selector.sv
// Scoreboard bench for wr_channel_rr_selector: per-port beat queues drive the inputs,
// expected beats are queued in hand-computed grant order and checked by a separate monitor.
`timescale 1ns/1ps
module tb_wr_channel_rr_selector;

  localparam int NP = 16;
  localparam int DW = 256;
  localparam int PW = 4;
  localparam int MB = 4;
`ifdef WSEL_TIMEOUT_EN
  localparam int EXP_TMO = 1;
`else
  localparam int EXP_TMO = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eop;
  } beat_t;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [DW-1:0] data;
    logic          eop;
    logic          tmo;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     in_valid;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_eop;
  logic [NP-1:0]     in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_eop;
  logic [PW-1:0]     out_port;
  logic              out_ready = 1'b1;
  logic [NP-1:0]     enabled;
  logic              busy;
  logic              timeout_err;

  beat_t         port_q [NP][$];
  exp_t          exp_q [$];
  logic [NP-1:0] acc;
  int            n_total = 0;
  int            n_bad = 0;
  int            tmo_seen = 0;

  wr_channel_rr_selector #(
    .NUM_PORTS(NP), .DATA_W(DW), .PORT_W(PW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_eop(out_eop), .out_port(out_port),
    .out_ready(out_ready), .enabled(enabled), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int tst, input int port, input int beat);
    logic [31:0] w;
    w = {8'(tst), 8'(port), 8'(beat), 8'hA5};
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input int tst, input int port, input int nbeats);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b.data = mk(tst, port, i);
      b.eop  = (i == nbeats - 1);
      port_q[port].push_back(b);
      e.port = PW'(port);
      e.data = b.data;
      e.eop  = b.eop;
      e.tmo  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0);
    for (int i = 0; i < NP; i++) if (port_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (pending()) begin
      n_bad++;
      $display("FAIL %s: %0d expected beats still outstanding after %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (out_valid !== 1'b1 && n < budget);
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: out_valid got %b expected 1 within %0d cycles", name, out_valid, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, DW'(out_valid), '0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_eop"}, DW'(out_eop), '0);
    check({tag, "_out_port"}, DW'(out_port), '0);
    check({tag, "_in_ready"}, DW'(in_ready), '0);
    check({tag, "_enabled"}, DW'(enabled), '0);
    check({tag, "_busy"}, DW'(busy), '0);
    check({tag, "_timeout_err"}, DW'(timeout_err), '0);
  endtask

  // Driver: each port presents the head of its queue until it is accepted.
  initial begin : driver
    in_valid = '0;
    in_data  = '0;
    in_eop   = '0;
    acc      = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++)
        if (acc[i] && port_q[i].size() > 0) void'(port_q[i].pop_front());
      for (int i = 0; i < NP; i++) begin
        if (port_q[i].size() > 0) begin
          in_valid[i]         = 1'b1;
          in_data[i*DW +: DW] = port_q[i][0].data;
          in_eop[i]           = port_q[i][0].eop;
        end else begin
          in_valid[i] = 1'b0;
          in_eop[i]   = 1'b0;
        end
      end
      #4;
      acc = (rst_n === 1'b1) ? (in_valid & in_ready) : '0;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1) begin
        if (busy === 1'b1) check("enabled_onehot", DW'($onehot(enabled)), DW'(1));
        else               check("enabled_idle", DW'(enabled), '0);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_beat: got port %0d data %0h expected no beat", out_port, out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_port", DW'(out_port), DW'(e.port));
            check("out_data", out_data, e.data);
            check("out_eop", DW'(out_eop), DW'(e.eop));
            check("timeout_err", DW'(timeout_err), DW'(e.tmo));
          end
        end
      end
    end
  end

  always @(negedge clk) if (rst_n === 1'b1 && timeout_err === 1'b1) tmo_seen++;

  initial begin : main
    exp_t e;
    beat_t b;

    // Reset with every port requesting; then two rounds of single-beat packets.
    for (int p = 0; p < NP; p++) send_pkt(1, p, 1);
    for (int p = 0; p < NP; p++) send_pkt(3, p, 1);
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("first_grant", DW'(enabled), DW'(16'h0001));
    check("first_busy", DW'(busy), DW'(1));
    wait_drain("rr_wrap", 300);

    // Ports 3 and 7, four beats each: pointer is 0, so 3 then 7.
    @(negedge clk);
    #1;
    send_pkt(2, 3, 4);
    send_pkt(2, 7, 4);
    wait_drain("two_pkts", 100);

    // Port 5, three beats, downstream stalled over beat 1.
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    send_pkt(4, 5, 3);
    wait_valid("stall_first", 20);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", DW'(out_valid), DW'(1));
      check("stall_data", out_data, mk(4, 5, 0));
      check("stall_in_ready", DW'(in_ready[5]), '0);
      @(negedge clk);
      #2;
    end
    out_ready = 1'b1;
    wait_drain("stall", 100);

    // Port 9, four beats, reset while beat 2 sits in the output register.
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      b.data = mk(5, 9, i);
      b.eop  = (i == 3);
      port_q[9].push_back(b);
    end
    e.port = PW'(9);
    e.data = mk(5, 9, 0);
    e.eop  = 1'b0;
    e.tmo  = 1'b0;
    exp_q.push_back(e);
    wait_valid("midrst_first", 20);
    @(negedge clk);
    #2;
    check("midrst_beat2", out_data, mk(5, 9, 1));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_zero("midrst");
    port_q[9].delete();
    @(negedge clk);
    #1;
    // Pointer back at 0: port 2 must win over port 12.
    send_pkt(7, 2, 1);
    send_pkt(7, 12, 1);
    rst_n = 1'b1;
    wait_drain("after_rst", 100);

`ifdef WSEL_TIMEOUT_EN
    // Port 2 streams six beats with no eop; the fourth is force-closed.
    @(negedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      b.data = mk(6, 2, i);
      b.eop  = 1'b0;
      port_q[2].push_back(b);
      e.port = PW'(2);
      e.data = b.data;
      e.eop  = (i == 3);
      e.tmo  = (i == 3);
      exp_q.push_back(e);
    end
    wait_drain("timeout", 100);
`endif

    check("tmo_pulses", DW'(tmo_seen), DW'(EXP_TMO));
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
